// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 4-bit ALU datapath and its operand entry stage.
//   OPW               : operand/opcode width
//   DEBOUNCE_DEFAULT  : debounce length in cycles (10 ms at 50 MHz)
//   entry_state_t     : operand entry FSM states; the encoding is also the
//                       value shown on the `phase` output
//   next_entry_state  : entry sequence ENT_A -> ENT_B -> ENT_OP -> SHOW -> ENT_A
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int OPW              = 4;
   localparam int DEBOUNCE_DEFAULT = 500000;

   typedef enum logic [1:0] {
      ENT_A  = 2'd0,
      ENT_B  = 2'd1,
      ENT_OP = 2'd2,
      SHOW   = 2'd3
   } entry_state_t;

   // Successor of a state on an enter press.
   function automatic entry_state_t next_entry_state(input entry_state_t s);
      entry_state_t n;
      case (s)
         ENT_A:   n = ENT_B;
         ENT_B:   n = ENT_OP;
         ENT_OP:  n = SHOW;
         SHOW:    n = ENT_A;
         default: n = ENT_A;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/operand_entry_if.sv
// -----------------------------------------------------------------------------
// operand_entry_if
// Bundle between the board controls and the operand entry stage.
//   sw        : raw slide switches (field value)
//   btn_enter : raw enter button, active high
//   btn_clr   : raw clear button, active high (only with OPERAND_ENTRY_CLR_EN)
//   a, b, sel : latched operands / opcode towards the ALU
//   phase     : current entry state encoding
//   valid     : all three fields committed
// Modports: master = board/test side, slave = operand_entry.
// Optional feature macro: OPERAND_ENTRY_CLR_EN
// -----------------------------------------------------------------------------
interface operand_entry_if;
   import alu_pkg::*;

   logic [OPW-1:0] sw;
   logic           btn_enter;
`ifdef OPERAND_ENTRY_CLR_EN
   logic           btn_clr;
`endif
   logic [OPW-1:0] a;
   logic [OPW-1:0] b;
   logic [OPW-1:0] sel;
   logic [1:0]     phase;
   logic           valid;

   modport master (
`ifdef OPERAND_ENTRY_CLR_EN
      output btn_clr,
`endif
      output sw, btn_enter,
      input  a, b, sel, phase, valid
   );

   modport slave (
`ifdef OPERAND_ENTRY_CLR_EN
      input  btn_clr,
`endif
      input  sw, btn_enter,
      output a, b, sel, phase, valid
   );

endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser, counter debouncer and registered rising-edge
// detector for one push-button.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_raw    : raw asynchronous button level
//   pulse      : one-cycle press pulse (releases produce nothing)
// The debounced level only flips after the synchronised level has differed
// from it on DEBOUNCE_CYCLES consecutive edges; any agreement restarts the
// count, so shorter glitches never get through.
// -----------------------------------------------------------------------------
module btn_debounce
   import alu_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic pulse
);

   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta_r;
   logic             sync_r;
   logic             level_r;
   logic             level_d_r;
   logic             pulse_r;
   logic [CNT_W-1:0] cnt_r;

   // Two-flop synchroniser for the raw button level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= btn_raw;
         sync_r <= meta_r;
      end
   end

   // Debounce counter; the level flips on the edge where the count has
   // already reached its last value and the levels still disagree.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r   <= CNT_ZERO;
         level_r <= 1'b0;
      end else if (sync_r == level_r) begin
         cnt_r   <= CNT_ZERO;
         level_r <= level_r;
      end else if (cnt_r == CNT_LAST) begin
         cnt_r   <= CNT_ZERO;
         level_r <= ~level_r;
      end else begin
         cnt_r   <= cnt_r + CNT_ONE;
         level_r <= level_r;
      end
   end

   // Registered rising-edge detector on the debounced level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_d_r <= 1'b0;
         pulse_r   <= 1'b0;
      end else begin
         level_d_r <= level_r;
         pulse_r   <= level_r & ~level_d_r;
      end
   end

   assign pulse = pulse_r;

endmodule

// File: rtl/operand_entry_chk.sv
// -----------------------------------------------------------------------------
// operand_entry_chk
// Property checker bound inside operand_entry; no logic of its own.
//   clk, rst_n            : clock, asynchronous active-low reset
//   enter_pulse, clr_pulse: debounced press pulses
//   state, valid          : entry FSM state and committed flag
//   a, b, sel             : field registers
// -----------------------------------------------------------------------------
module operand_entry_chk
   import alu_pkg::*;
(
   input logic           clk,
   input logic           rst_n,
   input logic           enter_pulse,
   input logic           clr_pulse,
   input entry_state_t   state,
   input logic           valid,
   input logic [OPW-1:0] a,
   input logic [OPW-1:0] b,
   input logic [OPW-1:0] sel
);

   // valid is a registered copy of "state is SHOW".
   a_valid_state : assert property (@(posedge clk) disable iff (!rst_n)
      valid == (state == SHOW));

   // A press never produces two consecutive pulse cycles.
   a_enter_single : assert property (@(posedge clk) disable iff (!rst_n)
      enter_pulse |=> !enter_pulse);

   // Fields only move when a press pulse was seen.
   a_fields_hold : assert property (@(posedge clk) disable iff (!rst_n)
      (!enter_pulse && !clr_pulse) |=> ($stable(a) && $stable(b) && $stable(sel)));

   // A clear pulse returns to an empty ENT_A on the next edge.
   a_clear : assert property (@(posedge clk) disable iff (!rst_n)
      clr_pulse |=> (state == ENT_A && a == 4'h0 && b == 4'h0 && sel == 4'h0 && !valid));

endmodule

// File: rtl/operand_entry.sv
// -----------------------------------------------------------------------------
// operand_entry
// Captures operand a, operand b and opcode sel in sequence from the slide
// switches, one field per debounced enter press, and presents them to the ALU.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : operand_entry_if.slave (sw, btn_enter, [btn_clr], a, b, sel,
//           phase, valid)
// Parameters: DEBOUNCE_CYCLES (press acceptance length), CNT_W (counter width)
// Optional feature macro: OPERAND_ENTRY_CLR_EN adds btn_clr, whose press
// returns to an empty ENT_A and wins over a simultaneous enter press.
// Fields keep their old value while a new entry is in progress so the ALU
// keeps computing on the previous operands.
// -----------------------------------------------------------------------------
module operand_entry
   import alu_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input logic             clk,
   input logic             rst_n,
   operand_entry_if.slave  bus
);

   logic           enter_pulse_s;
   logic           clr_pulse_s;
   logic [OPW-1:0] sw_meta_r;
   logic [OPW-1:0] sw_sync_r;

   entry_state_t   state_r;
   entry_state_t   state_nxt_s;
   logic [OPW-1:0] a_r;
   logic [OPW-1:0] b_r;
   logic [OPW-1:0] sel_r;
   logic [OPW-1:0] a_nxt_s;
   logic [OPW-1:0] b_nxt_s;
   logic [OPW-1:0] sel_nxt_s;
   logic           valid_r;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_enter_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (bus.btn_enter),
      .pulse   (enter_pulse_s)
   );

`ifdef OPERAND_ENTRY_CLR_EN
   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_clr_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (bus.btn_clr),
      .pulse   (clr_pulse_s)
   );
`else
   assign clr_pulse_s = 1'b0;
`endif

   // Switches are only synchronised; they are required to be stable well
   // before the enter pulse, so no debouncing is needed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_meta_r <= {OPW{1'b0}};
         sw_sync_r <= {OPW{1'b0}};
      end else begin
         sw_meta_r <= bus.sw;
         sw_sync_r <= sw_meta_r;
      end
   end

   // Next state and field values; clear takes priority over enter.
   always_comb begin
      state_nxt_s = state_r;
      a_nxt_s     = a_r;
      b_nxt_s     = b_r;
      sel_nxt_s   = sel_r;
      if (clr_pulse_s) begin
         state_nxt_s = ENT_A;
         a_nxt_s     = {OPW{1'b0}};
         b_nxt_s     = {OPW{1'b0}};
         sel_nxt_s   = {OPW{1'b0}};
      end else if (enter_pulse_s) begin
         state_nxt_s = next_entry_state(state_r);
         case (state_r)
            ENT_A:   a_nxt_s   = sw_sync_r;
            ENT_B:   b_nxt_s   = sw_sync_r;
            ENT_OP:  sel_nxt_s = sw_sync_r;
            SHOW:    a_nxt_s   = a_r;
            default: a_nxt_s   = a_r;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State, field and valid registers; valid is derived from the next state
   // so it changes on the same edge as the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ENT_A;
         a_r     <= {OPW{1'b0}};
         b_r     <= {OPW{1'b0}};
         sel_r   <= {OPW{1'b0}};
         valid_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         a_r     <= a_nxt_s;
         b_r     <= b_nxt_s;
         sel_r   <= sel_nxt_s;
         valid_r <= (state_nxt_s == SHOW);
      end
   end

   assign bus.a     = a_r;
   assign bus.b     = b_r;
   assign bus.sel   = sel_r;
   assign bus.phase = state_r;
   assign bus.valid = valid_r;

   operand_entry_chk u_chk (
      .clk         (clk),
      .rst_n       (rst_n),
      .enter_pulse (enter_pulse_s),
      .clr_pulse   (clr_pulse_s),
      .state       (state_r),
      .valid       (valid_r),
      .a           (a_r),
      .b           (b_r),
      .sel         (sel_r)
   );

endmodule

// File: tb/tb_operand_entry.sv
// -----------------------------------------------------------------------------
// tb_operand_entry
// Bench for operand_entry with DEBOUNCE_CYCLES = 4. A behavioural model tracks
// each button as "accepted once its synchronised level has disagreed with the
// accepted level for 4 straight cycles"; an accepted press schedules an entry
// event two edges later that advances a 0..3 phase counter and latches the
// switch value into the field chosen by that phase. Outputs are compared with
// the model on every falling edge, plus directed checks against constants.
// Optional feature macro: OPERAND_ENTRY_CLR_EN
// -----------------------------------------------------------------------------
module tb_operand_entry;
   import alu_pkg::*;

   localparam int D = 4;
`ifdef OPERAND_ENTRY_CLR_EN
   localparam bit HAS_CLR = 1'b1;
`else
   localparam bit HAS_CLR = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic clr_raw;

   operand_entry_if bus ();

   operand_entry #(.DEBOUNCE_CYCLES(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

`ifdef OPERAND_ENTRY_CLR_EN
   assign bus.btn_clr = clr_raw;
`endif

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int         due;
      bit         clr;
      logic [3:0] v;
   } ev_t;

   ev_t        evq[$];
   int         edge_n;
   int         m_phase;
   logic [3:0] m_a, m_b, m_sel;
   logic       hist1[2], hist2[2], acc[2];
   int         run[2];

   task automatic model_reset();
      evq.delete();
      m_phase = 0;
      m_a = 4'h0; m_b = 4'h0; m_sel = 4'h0;
      for (int i = 0; i < 2; i++) begin
         hist1[i] = 1'b0; hist2[i] = 1'b0; acc[i] = 1'b0; run[i] = 0;
      end
   endtask

   task automatic model_step();
      bit         do_clr, do_ent;
      logic [3:0] v;
      logic       raw;
      ev_t        e;
      edge_n++;
      do_clr = 1'b0; do_ent = 1'b0; v = 4'h0;
      while (evq.size() > 0 && evq[0].due == edge_n) begin
         e = evq.pop_front();
         if (e.clr) do_clr = 1'b1;
         else begin do_ent = 1'b1; v = e.v; end
      end
      if (do_clr) begin
         m_phase = 0; m_a = 4'h0; m_b = 4'h0; m_sel = 4'h0;
      end else if (do_ent) begin
         if (m_phase == 0) m_a = v;
         else if (m_phase == 1) m_b = v;
         else if (m_phase == 2) m_sel = v;
         m_phase = (m_phase + 1) % 4;
      end
      for (int i = 0; i < 2; i++) begin
         raw = (i == 0) ? bus.btn_enter : (HAS_CLR ? clr_raw : 1'b0);
         if (hist2[i] != acc[i]) begin
            run[i]++;
            if (run[i] == D) begin
               acc[i] = ~acc[i];
               run[i] = 0;
               if (acc[i]) begin
                  e.due = edge_n + 2; e.clr = (i == 1); e.v = bus.sw;
                  evq.push_back(e);
               end
            end
         end else begin
            run[i] = 0;
         end
         hist2[i] = hist1[i];
         hist1[i] = raw;
      end
   endtask

   initial begin
      edge_n = 0;
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // Continuous comparison against the model on falling edges.
   initial begin
      forever begin
         @(negedge clk);
         check_val("cyc_a",     {28'd0, bus.a},     {28'd0, m_a});
         check_val("cyc_b",     {28'd0, bus.b},     {28'd0, m_b});
         check_val("cyc_sel",   {28'd0, bus.sel},   {28'd0, m_sel});
         check_val("cyc_phase", {30'd0, bus.phase}, m_phase);
         check_val("cyc_valid", {31'd0, bus.valid}, (m_phase == 3) ? 32'd1 : 32'd0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic press(input logic [3:0] v, input int hold, input int gap, input bit with_clr);
      bus.sw = v;
      tick(4);
      bus.btn_enter = 1'b1;
      clr_raw = with_clr;
      tick(hold);
      bus.btn_enter = 1'b0;
      clr_raw = 1'b0;
      tick(gap);
   endtask

   task automatic check_outs(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                             input logic [3:0] es, input logic [1:0] ep, input logic ev);
      check_val({tag, "_a"},     {28'd0, bus.a},     {28'd0, ea});
      check_val({tag, "_b"},     {28'd0, bus.b},     {28'd0, eb});
      check_val({tag, "_sel"},   {28'd0, bus.sel},   {28'd0, es});
      check_val({tag, "_phase"}, {30'd0, bus.phase}, {30'd0, ep});
      check_val({tag, "_valid"}, {31'd0, bus.valid}, {31'd0, ev});
   endtask

   initial begin
      bus.sw = 4'h0;
      bus.btn_enter = 1'b0;
      clr_raw = 1'b0;

      // Reset and idle
      tick(5);
      check_outs("in_reset", 4'h0, 4'h0, 4'h0, 2'd0, 1'b0);
      rst_n = 1'b1;
      tick(100);
      check_outs("idle", 4'h0, 4'h0, 4'h0, 2'd0, 1'b0);

      // Full entry
      press(4'h6, 6, 12, 1'b0);
      check_outs("ent_a", 4'h6, 4'h0, 4'h0, 2'd1, 1'b0);
      press(4'hA, 6, 12, 1'b0);
      press(4'hF, 6, 12, 1'b0);
      check_outs("full", 4'h6, 4'hA, 4'hF, 2'd3, 1'b1);

      // Hold and wrap
      press(4'h9, 50, 12, 1'b0);
      check_outs("wrap", 4'h6, 4'hA, 4'hF, 2'd0, 1'b0);

      // Bounce rejection
      bus.sw = 4'h3;
      tick(4);
      for (int len = 1; len <= 3; len++) begin
         bus.btn_enter = 1'b1;
         tick(len);
         bus.btn_enter = 1'b0;
         tick(1);
      end
      tick(12);
      check_outs("bounce", 4'h6, 4'hA, 4'hF, 2'd0, 1'b0);
      press(4'h3, 6, 12, 1'b0);
      check_outs("after_bounce", 4'h3, 4'hA, 4'hF, 2'd1, 1'b0);

      // Reset mid-entry in ENT_B, button released during reset
      bus.sw = 4'h5;
      tick(4);
      bus.btn_enter = 1'b1;
      tick(4);
      rst_n = 1'b0;
      #1;
      check_outs("mid_rst", 4'h0, 4'h0, 4'h0, 2'd0, 1'b0);
      bus.btn_enter = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(20);
      check_outs("rst_released", 4'h0, 4'h0, 4'h0, 2'd0, 1'b0);

      // Button held across reset release is accepted after debounce
      bus.sw = 4'h7;
      tick(4);
      bus.btn_enter = 1'b1;
      tick(3);
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(10);
      bus.btn_enter = 1'b0;
      tick(12);
      check_outs("held_rst", 4'h7, 4'h0, 4'h0, 2'd1, 1'b0);

`ifdef OPERAND_ENTRY_CLR_EN
      // Clear and enter in the same cycle while in ENT_OP
      press(4'h2, 6, 12, 1'b0);
      check_outs("to_op", 4'h7, 4'h2, 4'h0, 2'd2, 1'b0);
      press(4'h4, 6, 12, 1'b1);
      check_outs("clr_win", 4'h0, 4'h0, 4'h0, 2'd0, 1'b0);
`endif

      // Randomised presses of varying length
      for (int i = 0; i < 40; i++) begin
         logic [3:0] v;
         int         hold, gap;
         bit         wc;
         v    = 4'($urandom_range(0, 15));
         hold = $urandom_range(1, 8);
         gap  = $urandom_range(8, 14);
         wc   = HAS_CLR && ($urandom_range(0, 4) == 0);
         press(v, hold, gap, wc);
      end
      tick(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
